// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART: 8-entry TX FIFO, single-byte RX holding register,
// programmable baud divider, one-cycle registered bus response.
`timescale 1ns/1ps
module uart_peripheral #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int RESET_DIV  = 867
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  output logic                  response,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  uart_tx,
  input  logic                  uart_rx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(FIFO_DEPTH);

  // state | meaning: IDLE line idle / hunting, START start bit, DATA 8 data bits, STOP stop bit
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_BAUD = 2'd2;

  logic                  r_response;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [15:0]           r_baud;

  logic [7:0]            r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PW:0]           r_count;

  logic [1:0]            r_tx_state;
  logic [15:0]           r_tx_cnt;
  logic [2:0]            r_tx_bit;
  logic [7:0]            r_tx_shift;
  logic                  r_tx;

  logic                  r_rx_s1, r_rx_s2;
  logic [1:0]            r_rx_state;
  logic [15:0]           r_rx_cnt;
  logic [2:0]            r_rx_bit;
  logic [7:0]            r_rx_shift, r_rx_byte;
  logic                  r_rx_valid, r_rx_overrun, r_tx_overflow, r_frame_err;

  logic                  w_accept, w_wr, w_rd;
  logic [1:0]            w_addr;
  logic                  w_fifo_full, w_fifo_empty, w_push, w_pop;
  logic                  w_tx_tick, w_rx_tick, w_rx_store, w_rx_ferr;
  logic                  w_data_rd, w_stat_wr;
  logic [6:0]            w_status;
  logic [DATA_WIDTH-1:0] w_rdata_next;
  logic                  w_unused;

  assign w_accept     = (read | write) & ~r_response;
  assign w_wr         = w_accept & write;
  assign w_rd         = w_accept & read & ~write;
  assign w_addr       = address[3:2];
  assign w_fifo_full  = (r_count == C_FULL);
  assign w_fifo_empty = (r_count == '0);
  assign w_push       = w_wr & (w_addr == A_DATA) & ~w_fifo_full;
  assign w_pop        = (r_tx_state == ST_IDLE) & ~w_fifo_empty;
  assign w_tx_tick    = (r_tx_cnt == '0);
  assign w_rx_tick    = (r_rx_cnt == '0);
  assign w_rx_store   = (r_rx_state == ST_STOP) & w_rx_tick & r_rx_s2;
  assign w_rx_ferr    = (r_rx_state == ST_STOP) & w_rx_tick & ~r_rx_s2;
  assign w_data_rd    = w_rd & (w_addr == A_DATA);
  assign w_stat_wr    = w_wr & (w_addr == A_STAT);
  assign w_status     = {r_frame_err, r_tx_overflow, r_rx_overrun, (r_tx_state != ST_IDLE),
                         r_rx_valid, w_fifo_full, w_fifo_empty};
  assign w_unused     = &{1'b0, address[ADDR_WIDTH-1:4], address[1:0], write_data[DATA_WIDTH-1:16]};

  assign response  = r_response;
  assign read_data = r_rdata;
  assign uart_tx   = r_tx;

  always_comb begin
    w_rdata_next = '0;
    case (w_addr)
      A_DATA:  w_rdata_next[7:0]  = r_rx_byte;
      A_STAT:  w_rdata_next[6:0]  = w_status;
      A_BAUD:  w_rdata_next[15:0] = r_baud;
      default: w_rdata_next       = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_response <= 1'b0;
      r_rdata    <= '0;
      r_baud     <= 16'(RESET_DIV);
    end else begin
      r_response <= w_accept;
      if (w_rd) r_rdata <= w_rdata_next;
      if (w_wr && (w_addr == A_BAUD)) r_baud <= write_data[15:0];
    end
  end

  // A flag being set in the same cycle as its clear-write wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_valid    <= 1'b0;
      r_rx_byte     <= '0;
      r_rx_overrun  <= 1'b0;
      r_tx_overflow <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      if (w_rx_store) begin
        r_rx_valid <= 1'b1;
        r_rx_byte  <= r_rx_shift;
      end else if (w_data_rd) begin
        r_rx_valid <= 1'b0;
      end
      r_rx_overrun  <= (w_rx_store & r_rx_valid & ~w_data_rd) |
                       (r_rx_overrun & ~(w_stat_wr & write_data[4]));
      r_tx_overflow <= (w_wr & (w_addr == A_DATA) & w_fifo_full) |
                       (r_tx_overflow & ~(w_stat_wr & write_data[5]));
      r_frame_err   <= w_rx_ferr | (r_frame_err & ~(w_stat_wr & write_data[6]));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Line is driven from a flop so reset forces it high without a glitch path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_tx_shift <= r_fifo[r_rd_ptr];
            r_tx_cnt   <= r_baud;
            r_tx       <= 1'b0;
            r_tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= r_baud;
            r_tx_bit   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= ST_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= r_baud;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= ST_STOP;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_tx     <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (w_tx_tick) r_tx_state <= ST_IDLE;
          else           r_tx_cnt   <= r_tx_cnt - 16'd1;
        end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // START re-checks the line half a bit after the falling edge to reject glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        ST_IDLE: begin
          if (!r_rx_s2) begin
            r_rx_cnt   <= r_baud >> 1;
            r_rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_rx_tick) begin
            if (!r_rx_s2) begin
              r_rx_cnt   <= r_baud;
              r_rx_bit   <= '0;
              r_rx_state <= ST_DATA;
            end else begin
              r_rx_state <= ST_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (w_rx_tick) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= r_baud;
            if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (w_rx_tick) r_rx_state <= ST_IDLE;
          else           r_rx_cnt   <= r_rx_cnt - 16'd1;
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// Scoreboarded bench for uart_peripheral: bus reads checked by a response
// monitor, serial output decoded by a line-level TX monitor.
`timescale 1ns/1ps
module tb_uart_peripheral;
  logic        clk = 1'b0;
  logic        rst, rd, wr, response, uart_tx, uart_rx;
  logic [31:0] address, write_data, read_data;

  uart_peripheral dut (
    .clk(clk), .rst(rst), .read(rd), .write(wr), .response(response),
    .address(address), .write_data(write_data), .read_data(read_data),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] exp;
    logic [31:0] msk;
    int          t;
    string       nm;
  } acc_t;

  acc_t       sbq[$];
  logic [7:0] txq[$];
  int         n_checks = 0, n_fail = 0;
  int         cyc = 0;
  int         tb_baud = 867;
  bit         b2b_mode = 0;
  int         burst_frames = 0;
  bit         m_rxv = 0, m_ovr = 0, m_ferr = 0, m_txovf = 0;
  logic [7:0] m_rxb = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit empty, input bit full, input bit busy);
    return {25'd0, m_ferr, m_txovf, m_ovr, busy, m_rxv, full, empty};
  endfunction

  task automatic bus(input bit is_wr, input logic [1:0] a, input logic [31:0] wd,
                     input logic [31:0] exp, input logic [31:0] msk, input string nm);
    acc_t e;
    @(negedge clk);
    wr         = is_wr;
    rd         = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
    address    = ($urandom & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
    write_data = wd;
    e.is_rd = !is_wr; e.exp = exp; e.msk = msk; e.t = cyc; e.nm = nm;
    sbq.push_back(e);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; write_data = $urandom;
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus(1'b0, a, 32'd0, exp, 32'hFFFF_FFFF, nm);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    bus(1'b1, a, wd, 32'd0, 32'd0, "wr");
  endtask

  task automatic send_rx(input logic [7:0] d, input bit stopb);
    logic [9:0] fr;
    int p;
    fr = {stopb, d, 1'b0};
    p  = tb_baud + 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); uart_rx = fr[k];
      repeat (p - 1) @(negedge clk);
    end
    if (!stopb) begin
      @(negedge clk); uart_rx = 1'b1;
    end
    if (stopb) begin
      if (m_rxv) m_ovr = 1;
      m_rxv = 1; m_rxb = d;
    end else begin
      m_ferr = 1;
    end
  endtask

  task automatic wait_tx(input int limit);
    for (int i = 0; i < limit && txq.size() > 0; i++) @(negedge clk);
    check("tx_drain", txq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Bus response monitor
  initial begin : resp_mon
    acc_t e;
    bit   prev_resp;
    prev_resp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin prev_resp = 0; continue; end
      if (response) begin
        check("resp_single_pulse", prev_resp, 0);
        if (sbq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL resp_unexpected: got response with no access pending");
        end else begin
          e = sbq.pop_front();
          check({e.nm, "_latency"}, cyc - e.t, 1);
          if (e.is_rd) check(e.nm, read_data & e.msk, e.exp & e.msk);
        end
      end
      prev_resp = response;
    end
  end

  // Serial line decoder
  initial begin : tx_mon
    int         idle, p;
    bit         ab, shape_ok;
    logic [9:0] bits;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst) begin idle = 0; continue; end
      if (uart_tx !== 1'b0) begin idle++; continue; end
      if (b2b_mode && burst_frames > 0) check("tx_gap", idle, 1);
      p = tb_baud + 1; ab = 0; shape_ok = 1; bits = '0;
      for (int k = 0; k < 10 && !ab; k++) begin
        for (int j = 0; j < p && !ab; j++) begin
          if (k != 0 || j != 0) @(negedge clk);
          if (rst) ab = 1;
          else if (j == 0) bits[k] = uart_tx;
          else if (uart_tx !== bits[k]) shape_ok = 0;
        end
      end
      idle = 0;
      if (!ab) begin
        burst_frames++;
        check("tx_start_stop", {bits[9], bits[0]}, 2'b10);
        check("tx_bit_hold", shape_ok, 1);
        if (txq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected: got frame %h with nothing expected", bits[8:1]);
        end else begin
          check("tx_byte", bits[8:1], txq.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] d, g;
    bit stayed;
    rst = 1; rd = 0; wr = 0; address = '0; write_data = '0; uart_rx = 1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_response", response, 0);
    check("rst_read_data", read_data, 0);
    rst = 0;

    rd_reg(1, exp_status(1, 0, 0), "reset_status");
    rd_reg(2, 32'd867, "reset_baud");
    rd_reg(3, 32'd0, "reserved_rd");
    wr_reg(3, $urandom);
    rd_reg(3, 32'd0, "reserved_rd2");
    rd_reg(1, exp_status(1, 0, 0), "status_after_rsv_wr");
    wr_reg(2, 32'hABCD_0003); tb_baud = 3;
    rd_reg(2, 32'd3, "baud_rw");

    // single byte
    txq.push_back(8'hA5);
    wr_reg(0, {24'($urandom), 8'hA5});
    check("tx_start_latency", uart_tx, 0);
    repeat (4) bus(1'b0, 2'd1, 32'd0, 32'h8, 32'h8, "tx_busy");
    wait_tx(1000);
    rd_reg(1, exp_status(1, 0, 0), "status_after_tx");

    // FIFO fill and overflow, back-to-back frames
    b2b_mode = 1; burst_frames = 0;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      if (txq.size() < 9) txq.push_back(d);
      else m_txovf = 1;
      wr_reg(0, {24'($urandom), d});
    end
    rd_reg(1, exp_status(0, 1, 1), "status_full_ovf");
    wr_reg(1, 32'h20); m_txovf = 0;
    rd_reg(1, exp_status(0, 1, 1), "status_ovf_clr");
    wait_tx(5000);
    b2b_mode = 0;
    rd_reg(1, exp_status(1, 0, 0), "status_after_burst");

    // receive with overrun
    send_rx(8'h3C, 1); send_rx(8'hC3, 1);
    repeat (12) @(negedge clk);
    rd_reg(1, exp_status(1, 0, 0), "status_rx_ovr");
    rd_reg(0, {24'd0, m_rxb}, "rx_data_ovr"); m_rxv = 0;
    rd_reg(1, exp_status(1, 0, 0), "status_rx_read");
    wr_reg(1, 32'h10); m_ovr = 0;

    // framing error leaves held byte intact
    g = 8'($urandom); d = 8'($urandom);
    send_rx(g, 1); send_rx(d, 0);
    repeat (20) @(negedge clk);
    rd_reg(1, exp_status(1, 0, 0), "status_ferr");
    rd_reg(0, {24'd0, m_rxb}, "rx_data_after_ferr"); m_rxv = 0;
    wr_reg(1, 32'h40); m_ferr = 0;
    rd_reg(1, exp_status(1, 0, 0), "status_ferr_clr");

    // one-cycle glitch
    @(negedge clk); uart_rx = 0;
    @(negedge clk); uart_rx = 1;
    repeat (60) @(negedge clk);
    rd_reg(1, exp_status(1, 0, 0), "status_glitch");

    // randomized traffic at a random divider
    tb_baud = $urandom_range(2, 7);
    wr_reg(2, tb_baud);
    rd_reg(2, tb_baud, "baud_rand");
    for (int i = 0; i < 5; i++) begin
      send_rx(8'($urandom), 1);
      repeat (2 * tb_baud + 6) @(negedge clk);
      rd_reg(0, {24'd0, m_rxb}, "rx_rand"); m_rxv = 0;
    end
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom); txq.push_back(d);
      wr_reg(0, {24'd0, d});
    end
    wait_tx(2000);
    rd_reg(1, exp_status(1, 0, 0), "status_after_rand");

    // reset in the middle of a frame
    txq.push_back(8'h00);
    wr_reg(0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom); txq.push_back(d);
      wr_reg(0, {24'd0, d});
    end
    repeat (tb_baud + 1) @(negedge clk);
    check("tx_low_before_rst", uart_tx, 0);
    rst = 1;
    #1;
    check("rst_async_tx", uart_tx, 1);
    txq.delete();
    m_rxv = 0; m_ovr = 0; m_ferr = 0; m_txovf = 0; tb_baud = 867;
    repeat (2) @(negedge clk);
    rst = 0;
    rd_reg(1, exp_status(1, 0, 0), "status_after_rst");
    rd_reg(2, 32'd867, "baud_after_rst");
    stayed = 1;
    repeat (30) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) stayed = 0;
    end
    check("tx_idle_after_rst", stayed, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
